// File: rtl/vga_pkg.sv
// Shared VGA constants and arbiter state encoding, common to the timing generator and
// the frame-buffer arbiter.
package vga_pkg;

  localparam int unsigned PIX_W     = 3;
  localparam int unsigned ADDR_W    = 19;
  localparam int unsigned H_ACTIVE  = 640;
  localparam int unsigned V_ACTIVE  = 480;
  localparam int unsigned FRAME_PIX = H_ACTIVE * V_ACTIVE;

  typedef enum logic [1:0] {
    ARB_OFF   = 2'd0,
    ARB_RUN   = 2'd1,
    ARB_FORCE = 2'd2
  } arb_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/vga_fb_arbiter_if.sv
// Writer channel and memory port of the frame-buffer arbiter; the arbiter is the slave,
// the writer/memory side is the master.
interface vga_fb_arbiter_if #(
  parameter int unsigned ADDR_W = vga_pkg::ADDR_W,
  parameter int unsigned PIX_W  = vga_pkg::PIX_W
);
  logic              iWrReq;
  logic [ADDR_W-1:0] iWrAddr;
  logic [PIX_W-1:0]  iWrData;
  logic              oWrAck;
  logic [ADDR_W-1:0] oMemAddr;
  logic              oMemWe;
  logic [PIX_W-1:0]  oMemWData;
  logic [PIX_W-1:0]  iMemRData;

  modport slave (
    input  iWrReq, iWrAddr, iWrData, iMemRData,
    output oWrAck, oMemAddr, oMemWe, oMemWData
  );

  modport master (
    output iWrReq, iWrAddr, iWrData, iMemRData,
    input  oWrAck, oMemAddr, oMemWe, oMemWData
  );
endinterface

// File: rtl/vga_scan_addr.sv
// Scan-out address counter: reloads on frame start, advances per fetch, wraps at FRAME_PIX.
module vga_scan_addr #(
  parameter int unsigned ADDR_W    = vga_pkg::ADDR_W,
  parameter int unsigned FRAME_PIX = vga_pkg::FRAME_PIX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_frame_start,
  input  logic              i_adv,
  output logic [ADDR_W-1:0] o_addr
);
  import vga_pkg::*;

  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_cur;
  logic [ADDR_W-1:0] w_next;

  // Frame start takes effect in the same cycle so a coincident fetch reads address 0.
  always_comb begin
    w_cur  = i_frame_start ? '0 : r_addr;
    w_next = w_cur;
    if (i_adv) begin
      w_next = (w_cur == ADDR_W'(FRAME_PIX - 1)) ? '0 : w_cur + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr <= '0;
    end else begin
      r_addr <= w_next;
    end
  end

  assign o_addr = w_cur;

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port frame-buffer arbiter: scan-out fetches win by default, a starvation guard
// forces a write slot after MAX_WAIT cycles and counts the displaced fetches.
module vga_fb_arbiter #(
  parameter int unsigned ADDR_W    = vga_pkg::ADDR_W,
  parameter int unsigned PIX_W     = vga_pkg::PIX_W,
  parameter int unsigned FRAME_PIX = vga_pkg::FRAME_PIX,
  parameter int unsigned MAX_WAIT  = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   iEnable,
  input  logic                   iFrameStart,
  input  logic                   iPixReq,
  vga_fb_arbiter_if.slave        bus,
  output logic [PIX_W-1:0]       oPixData,
  output logic [15:0]            oMissCnt
);
  import vga_pkg::*;

  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

  arb_state_e        r_state;
  arb_state_e        w_state_d;
  logic [WAIT_W-1:0] r_wait;
  logic [WAIT_W-1:0] w_wait_d;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [ADDR_W-1:0] w_scan_addr;
  logic              w_rd;
  logic              w_we;
  logic              w_scan_adv;
  logic              w_miss;
  logic              r_rd_pend;
  logic [PIX_W-1:0]  r_pix;
  logic [15:0]       r_miss;

  vga_scan_addr #(
    .ADDR_W    (ADDR_W),
    .FRAME_PIX (FRAME_PIX)
  ) u_scan_addr (
    .clk           (clk),
    .rst           (rst),
    .i_frame_start (iFrameStart),
    .i_adv         (w_scan_adv),
    .o_addr        (w_scan_addr)
  );

  // Grant decode: which memory operation (if any) is issued this cycle.
  always_comb begin
    w_rd       = 1'b0;
    w_we       = 1'b0;
    w_scan_adv = 1'b0;
    w_miss     = 1'b0;
    unique case (r_state)
      ARB_RUN: begin
        if (iPixReq) begin
          w_rd       = 1'b1;
          w_scan_adv = 1'b1;
        end else if (bus.iWrReq) begin
          w_we = 1'b1;
        end
      end
      ARB_FORCE: begin
        if (bus.iWrReq) begin
          w_we       = 1'b1;
          w_scan_adv = iPixReq;
          w_miss     = iPixReq;
        end else if (iPixReq) begin
          w_rd       = 1'b1;
          w_scan_adv = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    w_mem_addr = r_mem_addr;
    if (w_rd) begin
      w_mem_addr = w_scan_addr;
    end else if (w_we) begin
      w_mem_addr = bus.iWrAddr;
    end
  end

  always_comb begin
    w_wait_d = r_wait;
    if (!bus.iWrReq || w_we) begin
      w_wait_d = '0;
    end else if (r_wait != WAIT_W'(MAX_WAIT)) begin
      w_wait_d = r_wait + WAIT_W'(1);
    end
  end

  // Force is taken on the edge where the wait counter reaches its limit.
  always_comb begin
    w_state_d = r_state;
    if (!iEnable) begin
      w_state_d = ARB_OFF;
    end else begin
      unique case (r_state)
        ARB_OFF:   w_state_d = ARB_RUN;
        ARB_RUN: begin
          if (bus.iWrReq && (w_wait_d == WAIT_W'(MAX_WAIT))) begin
            w_state_d = ARB_FORCE;
          end
        end
        ARB_FORCE: w_state_d = ARB_RUN;
        default:   w_state_d = ARB_OFF;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ARB_OFF;
      r_wait     <= '0;
      r_mem_addr <= '0;
      r_rd_pend  <= 1'b0;
      r_pix      <= '0;
      r_miss     <= '0;
    end else begin
      r_state    <= w_state_d;
      r_wait     <= w_wait_d;
      r_mem_addr <= w_mem_addr;
      r_rd_pend  <= w_rd;
      if (r_state == ARB_OFF) begin
        r_pix <= '0;
      end else if (r_rd_pend) begin
        r_pix <= bus.iMemRData;
      end
      if (w_miss) begin
        r_miss <= sat_inc16(r_miss);
      end
    end
  end

  assign bus.oWrAck    = w_we;
  assign bus.oMemWe    = w_we;
  assign bus.oMemAddr  = w_mem_addr;
  assign bus.oMemWData = w_we ? bus.iWrData : '0;
  assign oPixData      = (r_state == ARB_OFF) ? '0 : r_pix;
  assign oMissCnt      = r_miss;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter with a small frame and a short starvation limit.
module tb_vga_fb_arbiter;

  logic       clk;
  logic       rst;
  logic       en;
  logic       fs;
  logic       pix_req;
  logic [2:0] pix_data;
  logic [15:0] miss_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  vga_fb_arbiter_if #(.ADDR_W(19), .PIX_W(3)) bus ();

  vga_fb_arbiter #(
    .ADDR_W    (19),
    .PIX_W     (3),
    .FRAME_PIX (128),
    .MAX_WAIT  (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .iEnable     (en),
    .iFrameStart (fs),
    .iPixReq     (pix_req),
    .bus         (bus),
    .oPixData    (pix_data),
    .oMissCnt    (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous single-port memory, one-cycle read latency; preloaded while in reset.
  logic [2:0] mem [128];
  logic [2:0] rdata_q;
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 128; i++) mem[i] <= 3'((i % 7) + 1);
      rdata_q <= '0;
    end else begin
      if (bus.oMemWe) mem[bus.oMemAddr[6:0]] <= bus.oMemWData;
      rdata_q <= mem[bus.oMemAddr[6:0]];
    end
  end
  assign bus.iMemRData = rdata_q;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic force_miss(input int exp_miss);
    bit seen;
    seen = 1'b0;
    pix_req = 1'b1;
    bus.iWrReq = 1'b1;
    bus.iWrAddr = 19'd80;
    bus.iWrData = 3'd1;
    for (int i = 0; i < 12 && !seen; i++) begin
      settle();
      if (bus.oWrAck) seen = 1'b1;
      tick();
    end
    check("force_ack_seen", 32'(seen), 32'd1);
    bus.iWrReq = 1'b0;
    pix_req = 1'b0;
    settle();
    check("force_miss_cnt", 32'(miss_cnt), 32'(exp_miss));
    tick();
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; fs = 1'b0; pix_req = 1'b0;
    bus.iWrReq = 1'b0; bus.iWrAddr = '0; bus.iWrData = '0;
    #2;
    check("rst_addr",  32'(bus.oMemAddr),  32'd0);
    check("rst_we",    32'(bus.oMemWe),    32'd0);
    check("rst_wdata", 32'(bus.oMemWData), 32'd0);
    check("rst_ack",   32'(bus.oWrAck),    32'd0);
    check("rst_pix",   32'(pix_data),      32'd0);
    check("rst_miss",  32'(miss_cnt),      32'd0);
    @(posedge clk);
    #3 rst = 1'b1;
    tick();

    en = 1'b1;
    settle();
    check("off_pix", 32'(pix_data), 32'd0);
    tick();

    // Four fetches from frame start; pixels appear two cycles after each request.
    for (int k = 0; k < 6; k++) begin
      pix_req = (k < 4);
      fs = (k == 0);
      settle();
      if (k < 4) check("fetch_addr", 32'(bus.oMemAddr), 32'(k));
      if (k >= 2) check("fetch_pix", 32'(pix_data), 32'(k - 1));
      tick();
    end
    pix_req = 1'b0;
    fs = 1'b0;

    bus.iWrReq = 1'b1; bus.iWrAddr = 19'd100; bus.iWrData = 3'd5;
    settle();
    check("wr_we",    32'(bus.oMemWe),    32'd1);
    check("wr_addr",  32'(bus.oMemAddr),  32'd100);
    check("wr_ack",   32'(bus.oWrAck),    32'd1);
    check("wr_wdata", 32'(bus.oMemWData), 32'd5);
    tick();
    bus.iWrReq = 1'b0;
    settle();
    check("idle_ack",   32'(bus.oWrAck),    32'd0);
    check("idle_we",    32'(bus.oMemWe),    32'd0);
    check("idle_wdata", 32'(bus.oMemWData), 32'd0);
    check("idle_addr",  32'(bus.oMemAddr),  32'd100);
    tick();

    for (int k = 0; k <= 102; k++) begin
      pix_req = (k <= 100);
      fs = (k == 0);
      settle();
      if (k == 100) check("scan_addr_100", 32'(bus.oMemAddr), 32'd100);
      if (k == 102) check("readback_100", 32'(pix_data), 32'd5);
      tick();
    end
    fs = 1'b0;

    for (int k = 101; k <= 128; k++) begin
      pix_req = 1'b1;
      settle();
      if (k == 127) check("scan_last", 32'(bus.oMemAddr), 32'd127);
      if (k == 128) check("scan_wrap", 32'(bus.oMemAddr), 32'd0);
      tick();
    end

    fs = 1'b1;
    settle();
    check("fs_coincide_addr", 32'(bus.oMemAddr), 32'd0);
    tick();
    fs = 1'b0;
    settle();
    check("fs_next_addr", 32'(bus.oMemAddr), 32'd1);
    tick();

    // Scan address is 2: writer starves behind continuous fetches.
    bus.iWrAddr = 19'd50; bus.iWrData = 3'd6;
    for (int c = 0; c < 8; c++) begin
      bus.iWrReq = (c <= 4);
      pix_req = (c <= 5);
      settle();
      if (c < 4) check("starve_noack", 32'(bus.oWrAck), 32'd0);
      if (c == 4) begin
        check("force_ack",   32'(bus.oWrAck),    32'd1);
        check("force_addr",  32'(bus.oMemAddr),  32'd50);
        check("force_wdata", 32'(bus.oMemWData), 32'd6);
        check("force_pix",   32'(pix_data),      32'd5);
      end
      if (c == 5) begin
        check("after_force_addr", 32'(bus.oMemAddr), 32'd7);
        check("miss_one",         32'(miss_cnt),      32'd1);
        check("pix_before_drop",  32'(pix_data),      32'd6);
      end
      if (c == 6) check("pix_repeat", 32'(pix_data), 32'd6);
      if (c == 7) check("pix_resume", 32'(pix_data), 32'd1);
      tick();
    end

    en = 1'b0; pix_req = 1'b1;
    bus.iWrReq = 1'b1; bus.iWrAddr = 19'd60; bus.iWrData = 3'd7;
    settle();
    check("drop_noack_run", 32'(bus.oWrAck), 32'd0);
    tick();
    pix_req = 1'b0;
    for (int d = 1; d <= 2; d++) begin
      settle();
      check("off_noack", 32'(bus.oWrAck), 32'd0);
      check("off_we",    32'(bus.oMemWe), 32'd0);
      check("off_pix0",  32'(pix_data),   32'd0);
      tick();
    end
    bus.iWrReq = 1'b0;
    tick();

    en = 1'b1;
    tick();
    force_miss(2);
    force_miss(3);

    pix_req = 1'b1;
    bus.iWrReq = 1'b1; bus.iWrAddr = 19'd70; bus.iWrData = 3'd3;
    settle();
    check("pre_rst_noack", 32'(bus.oWrAck), 32'd0);
    rst = 1'b0;
    #1;
    check("mid_rst_ack",   32'(bus.oWrAck),    32'd0);
    check("mid_rst_we",    32'(bus.oMemWe),    32'd0);
    check("mid_rst_addr",  32'(bus.oMemAddr),  32'd0);
    check("mid_rst_wdata", 32'(bus.oMemWData), 32'd0);
    check("mid_rst_pix",   32'(pix_data),      32'd0);
    check("mid_rst_miss",  32'(miss_cnt),      32'd0);
    tick();
    rst = 1'b1;
    pix_req = 1'b0;
    settle();
    check("post_rst_off_noack", 32'(bus.oWrAck), 32'd0);
    tick();
    settle();
    check("rewrite_ack",   32'(bus.oWrAck),    32'd1);
    check("rewrite_addr",  32'(bus.oMemAddr),  32'd70);
    check("rewrite_we",    32'(bus.oMemWe),    32'd1);
    check("rewrite_wdata", 32'(bus.oMemWData), 32'd3);
    tick();
    bus.iWrReq = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
